// File: rtl/wb_retire_stage.sv
// wb_retire_stage: writeback stage with a DEPTH-entry in-order retire queue
// sitting between the MEM stage and the register-file write port.
//
// - MEM results enter on a mem_valid / wb_allow_in handshake and are written
//   at the queue tail; they become visible at the head the following cycle.
// - The head retires through a write port that may stall via rf_ready.
//   Entries that do not write a GPR (gr_we=0 or dest=r0) retire in one cycle
//   without raising rf_we.
// - Two combinational forwarding ports search every queued entry and return
//   the youngest matching producer.
// - The debug trace reflects the head entry; debug_wb_rf_we marks the cycle
//   on which a register write is actually committed.
//
// Optional build macro: WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output that
// counts every retired entry (including r0 and no-write entries).
`timescale 1ns/1ps

module wb_retire_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    // MEM -> WB handshake
    input  logic            mem_valid,
    output logic            wb_allow_in,
    input  logic [PC_W-1:0] in_pc,
    input  logic [RA_W-1:0] in_dest,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_gr_we,
    // register-file write port
    output logic            rf_we,
    input  logic            rf_ready,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    // forwarding queries
    input  logic [RA_W-1:0] fq0_addr,
    input  logic [RA_W-1:0] fq1_addr,
    output logic            fq0_hit,
    output logic            fq1_hit,
    output logic [XLEN-1:0] fq0_data,
    output logic [XLEN-1:0] fq1_data,
    // status
    output logic            wb_empty,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     retire_cnt,
`endif
    // debug trace
    output logic [PC_W-1:0] debug_wb_pc,
    output logic [3:0]      debug_wb_rf_we,
    output logic [RA_W-1:0] debug_wb_rf_wnum,
    output logic [XLEN-1:0] debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [RA_W-1:0]  RA_ZERO  = {RA_W{1'b0}};

    // ------------------------------------------------------------------
    // Queue storage (packed so it can be handed to the lookup function)
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][PC_W-1:0] pc_mem_r;
    logic [DEPTH-1:0][RA_W-1:0] dest_mem_r;
    logic [DEPTH-1:0][XLEN-1:0] result_mem_r;
    logic [DEPTH-1:0]           gr_we_mem_r;

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // head view and handshake terms
    logic            head_valid_s;
    logic [PC_W-1:0] head_pc_s;
    logic [RA_W-1:0] head_dest_s;
    logic [XLEN-1:0] head_result_s;
    logic            head_gr_we_s;
    logic            head_writes_s;
    logic            push_s;
    logic            pop_s;
    logic            commit_s;

    // ------------------------------------------------------------------
    // Forwarding lookup: walk the valid entries oldest to youngest so the
    // last match seen (the youngest producer) wins. r0 never matches.
    // Returns {hit, data}; data is zero when there is no hit.
    // ------------------------------------------------------------------
    function automatic logic [XLEN:0] fwd_lookup(
        input logic [RA_W-1:0]              addr,
        input logic [PTR_W-1:0]             rd_ptr,
        input logic [CNT_W-1:0]             cnt,
        input logic [DEPTH-1:0]             we_v,
        input logic [DEPTH-1:0][RA_W-1:0]   dest_v,
        input logic [DEPTH-1:0][XLEN-1:0]   res_v
    );
        logic            hit;
        logic [XLEN-1:0] data;
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = {XLEN{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            // pointer arithmetic wraps naturally because DEPTH is a power of two
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && we_v[idx] &&
                (dest_v[idx] == addr) && (addr != RA_ZERO)) begin
                hit  = 1'b1;
                data = res_v[idx];
            end
        end
        return {hit, data};
    endfunction

    // Head entry selection from the read pointer.
    always_comb begin
        head_valid_s  = (count_r != CNT_ZERO);
        head_pc_s     = pc_mem_r[rd_ptr_r];
        head_dest_s   = dest_mem_r[rd_ptr_r];
        head_result_s = result_mem_r[rd_ptr_r];
        head_gr_we_s  = gr_we_mem_r[rd_ptr_r];
    end

    // Handshake: a no-write head retires without waiting on the write port,
    // and a full queue can still accept when the head leaves this cycle.
    always_comb begin
        head_writes_s = head_gr_we_s & (head_dest_s != RA_ZERO);
        pop_s         = head_valid_s & (rf_ready | ~head_writes_s);
        wb_allow_in   = (count_r < CNT_FULL) | pop_s;
        push_s        = mem_valid & wb_allow_in;
    end

    // Write request to the register file; suppressed in the reset cycle so
    // a dropped entry can never land in the register file.
    always_comb begin
        rf_we    = head_valid_s & head_writes_s & ~reset;
        commit_s = rf_we & rf_ready;
        wb_empty = ~head_valid_s;
    end

    // Head fields on the write port and debug trace, zeroed while empty.
    always_comb begin
        if (head_valid_s) begin
            rf_waddr          = head_dest_s;
            rf_wdata          = head_result_s;
            debug_wb_pc       = head_pc_s;
            debug_wb_rf_wnum  = head_dest_s;
            debug_wb_rf_wdata = head_result_s;
        end else begin
            rf_waddr          = RA_ZERO;
            rf_wdata          = {XLEN{1'b0}};
            debug_wb_pc       = {PC_W{1'b0}};
            debug_wb_rf_wnum  = RA_ZERO;
            debug_wb_rf_wdata = {XLEN{1'b0}};
        end
        debug_wb_rf_we = {4{commit_s}};
    end

    // Forwarding ports: both search the same queue contents.
    always_comb begin
        {fq0_hit, fq0_data} = fwd_lookup(fq0_addr, rd_ptr_r, count_r,
                                         gr_we_mem_r, dest_mem_r, result_mem_r);
        {fq1_hit, fq1_data} = fwd_lookup(fq1_addr, rd_ptr_r, count_r,
                                         gr_we_mem_r, dest_mem_r, result_mem_r);
    end

    // Entry storage: capture the MEM result at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_mem_r     <= {DEPTH{{PC_W{1'b0}}}};
            dest_mem_r   <= {DEPTH{RA_ZERO}};
            result_mem_r <= {DEPTH{{XLEN{1'b0}}}};
            gr_we_mem_r  <= {DEPTH{1'b0}};
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]     <= in_pc;
            dest_mem_r[wr_ptr_r]   <= in_dest;
            result_mem_r[wr_ptr_r] <= in_result;
            gr_we_mem_r[wr_ptr_r]  <= in_gr_we;
        end else begin
            pc_mem_r     <= pc_mem_r;
            dest_mem_r   <= dest_mem_r;
            result_mem_r <= result_mem_r;
            gr_we_mem_r  <= gr_we_mem_r;
        end
    end

    // Read/write pointers advance independently and wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
        end else begin
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_r;

    // Retire counter: one step per popped entry, whatever kind it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_r <= 64'd0;
        end else if (pop_s) begin
            retire_cnt_r <= retire_cnt_r + 64'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Scoreboard bench for wb_retire_stage (default parameters, DEPTH=2).
// The reference model is an ordered queue of accepted entries: the front is
// the head, the back is the youngest. A monitor compares the DUT against it
// on every falling edge; a tracker appends accepted stimulus.
`timescale 1ns/1ps

module tb_wb_retire_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        wb_allow_in;
    logic [31:0] in_pc;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        in_gr_we;
    logic        rf_we;
    logic        rf_ready;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  fq0_addr, fq1_addr;
    logic        fq0_hit, fq1_hit;
    logic [31:0] fq0_data, fq1_data;
    logic        wb_empty;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int     errors = 0;
    int     checks = 0;
    ent_t   exp_q[$];
    logic   allow_now = 1'b0;
    logic   accepted  = 1'b0;
    longint exp_cnt   = 0;

    wb_retire_stage #(.XLEN(32), .PC_W(32), .RA_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .wb_allow_in(wb_allow_in),
        .in_pc(in_pc), .in_dest(in_dest), .in_result(in_result), .in_gr_we(in_gr_we),
        .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fq0_addr(fq0_addr), .fq1_addr(fq1_addr),
        .fq0_hit(fq0_hit), .fq1_hit(fq1_hit),
        .fq0_data(fq0_data), .fq1_data(fq1_data),
        .wb_empty(wb_empty),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Youngest-first search of the model queue.
    function automatic logic [32:0] ref_fwd(input logic [4:0] a);
        if (a != 5'd0) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].we && exp_q[i].dest == a) return {1'b1, exp_q[i].res};
            end
        end
        return 33'd0;
    endfunction

    // Monitor: compare every output against the model, then retire the head.
    always @(negedge clk) begin : monitor
        int         sz;
        ent_t       h;
        logic       writes;
        logic       ewe;
        logic       p;
        logic [32:0] f0;
        logic [32:0] f1;
        sz     = exp_q.size();
        writes = 1'b0;
        p      = 1'b0;
        chk("wb_empty", {63'd0, wb_empty}, {63'd0, sz == 0});
        if (sz > 0) begin
            h      = exp_q[0];
            writes = h.we && (h.dest != 5'd0);
            p      = rf_ready || !writes;
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, h.dest});
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, h.res});
            chk("debug_wb_pc", {32'd0, debug_wb_pc}, {32'd0, h.pc});
            chk("debug_wb_rf_wnum", {59'd0, debug_wb_rf_wnum}, {59'd0, h.dest});
            chk("debug_wb_rf_wdata", {32'd0, debug_wb_rf_wdata}, {32'd0, h.res});
        end
        ewe = writes && !reset;
        chk("rf_we", {63'd0, rf_we}, {63'd0, ewe});
        chk("debug_wb_rf_we", {60'd0, debug_wb_rf_we}, {60'd0, {4{ewe && rf_ready}}});
        chk("wb_allow_in", {63'd0, wb_allow_in}, {63'd0, (sz < DEPTH) || p});
        f0 = ref_fwd(fq0_addr);
        f1 = ref_fwd(fq1_addr);
        chk("fq0_hit", {63'd0, fq0_hit}, {63'd0, f0[32]});
        chk("fq0_data", {32'd0, fq0_data}, {32'd0, f0[31:0]});
        chk("fq1_hit", {63'd0, fq1_hit}, {63'd0, f1[32]});
        chk("fq1_data", {32'd0, fq1_data}, {32'd0, f1[31:0]});
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, exp_cnt);
`endif
        allow_now = (sz < DEPTH) || p;
        if (reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (p) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
    end

    // Tracker: an issued entry joins the expected queue once it is accepted.
    always @(negedge clk) begin
        #1;
        accepted = 1'b0;
        if (!reset && mem_valid && allow_now) begin
            exp_q.push_back('{pc: in_pc, dest: in_dest, res: in_result, we: in_gr_we});
            accepted = 1'b1;
        end
    end

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] d,
                          input logic [31:0] r, input logic we, input logic rdy);
        @(posedge clk);
        #1;
        mem_valid = v; in_pc = pc; in_dest = d; in_result = r; in_gr_we = we; rf_ready = rdy;
    endtask

    // Hold one entry on the input until accepted (bounded).
    task automatic send(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r,
                        input logic we, input logic rdy);
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, pc, d, r, we, rdy);
            @(negedge clk);
            #2;
            if (accepted) return;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input logic rdy, input int n);
        repeat (n) set_in(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, rdy);
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            set_in(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) return;
        end
        chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; mem_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; in_pc = 32'd0; in_dest = 5'd0;
        in_result = 32'd0; in_gr_we = 1'b0; rf_ready = 1'b0;
        fq0_addr = 5'd5; fq1_addr = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #3;
        chk("reset_allow_in", {63'd0, wb_allow_in}, 64'd1);
        chk("reset_empty", {63'd0, wb_empty}, 64'd1);
        chk("reset_rf_we", {63'd0, rf_we}, 64'd0);

        // basic retire
        send(32'h1c00_0000, 5'd5, 32'h1234, 1'b1, 1'b1);
        idle(1'b1, 1);
        @(negedge clk);
        #3;
        chk("basic_rf_we", {63'd0, rf_we}, 64'd1);
        chk("basic_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("basic_wdata", {32'd0, rf_wdata}, 64'h1234);
        chk("basic_dbg_we", {60'd0, debug_wb_rf_we}, 64'hf);
        idle(1'b1, 1);
        @(negedge clk);
        #3;
        chk("basic_empty_after", {63'd0, wb_empty}, 64'd1);

        // backpressure: two accepted, third waits for the first pop
        send(32'h1c00_0010, 5'd1, 32'h11, 1'b1, 1'b0);
        send(32'h1c00_0014, 5'd2, 32'h22, 1'b1, 1'b0);
        set_in(1'b1, 32'h1c00_0018, 5'd3, 32'h33, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        chk("bp_allow_in", {63'd0, wb_allow_in}, 64'd0);
        chk("bp_rf_we_held", {63'd0, rf_we}, 64'd1);
        chk("bp_waddr_first", {59'd0, rf_waddr}, 64'd1);
        send(32'h1c00_0018, 5'd3, 32'h33, 1'b1, 1'b1);
        drain();

        // r0 and no-write entries retire without the write port
        send(32'h1c00_0020, 5'd0, 32'h55, 1'b1, 1'b0);
        send(32'h1c00_0024, 5'd7, 32'h66, 1'b0, 1'b0);
        idle(1'b0, 3);
        @(negedge clk);
        #3;
        chk("r0_drained", {63'd0, wb_empty}, 64'd1);

        // forwarding priority
        fq0_addr = 5'd3; fq1_addr = 5'd0;
        send(32'h1c00_0030, 5'd3, 32'hAAAA, 1'b1, 1'b0);
        send(32'h1c00_0034, 5'd3, 32'hBBBB, 1'b1, 1'b0);
        idle(1'b0, 1);
        @(negedge clk);
        #3;
        chk("fwd_hit0", {63'd0, fq0_hit}, 64'd1);
        chk("fwd_data0", {32'd0, fq0_data}, 64'hBBBB);
        chk("fwd_hit1", {63'd0, fq1_hit}, 64'd0);

        // reset with a full stalled queue
        pulse_reset();
        @(negedge clk);
        #3;
        chk("rst_mid_empty", {63'd0, wb_empty}, 64'd1);
        chk("rst_mid_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_mid_fq0", {63'd0, fq0_hit}, 64'd0);
        chk("rst_mid_dbg", {60'd0, debug_wb_rf_we}, 64'd0);

        // randomized traffic with small register range to force matches
        for (int c = 0; c < 400; c++) begin
            fq0_addr = 5'($urandom_range(0, 7));
            fq1_addr = 5'($urandom_range(0, 7));
            set_in(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
                   $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        drain();

        // retire counter: five entries including one r0 write
        pulse_reset();
        send(32'h1c00_0100, 5'd1, 32'h1, 1'b1, 1'b1);
        send(32'h1c00_0104, 5'd0, 32'h2, 1'b1, 1'b1);
        send(32'h1c00_0108, 5'd2, 32'h3, 1'b1, 1'b1);
        send(32'h1c00_010c, 5'd3, 32'h4, 1'b0, 1'b1);
        send(32'h1c00_0110, 5'd4, 32'h5, 1'b1, 1'b1);
        drain();
`ifdef WB_RETIRE_CNT_EN
        @(negedge clk);
        #3;
        chk("retire_cnt_five", retire_cnt, 64'd5);
`endif
        idle(1'b1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
Parametrised writeback stage with a DEPTH-entry in-order retire queue between the MEM stage and the register-file write port. Accepts MEM results on a valid/allow_in handshake and retires them in order through a write port that may stall via rf_ready. Provides two forwarding query ports that search all queued entries, youngest first, and drives the standard debug trace on every retire.

Parameters:
XLEN, 32, data and result width
PC_W, 32, PC width
RA_W, 5, register address width
DEPTH, 2, retire queue entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_valid  in  1  MEM has an entry for WB
wb_allow_in  out  1  WB accepts this cycle
in_pc  in  PC_W  instruction PC
in_dest  in  RA_W  destination register
in_result  in  XLEN  final result
in_gr_we  in  1  writes GPR
rf_we  out  1  write request (head valid, gr_we, dest!=0)
rf_ready  in  1  write port grants this cycle
rf_waddr  out  RA_W  head dest
rf_wdata  out  XLEN  head result
fq0_addr, fq1_addr  in  RA_W  forwarding query addresses
fq0_hit, fq1_hit  out  1  queued producer exists
fq0_data, fq1_data  out  XLEN  youngest matching result
wb_empty  out  1  queue empty
debug_wb_pc  out  PC_W  retiring PC
debug_wb_rf_we  out  4  {4{write committed}}
debug_wb_rf_wnum  out  RA_W  retiring dest
debug_wb_rf_wdata  out  XLEN  retiring data

Behaviour:
- Reset: queue empty, pointers and count 0. wb_allow_in=1, rf_we=0, fq*_hit=0, wb_empty=1, debug_wb_rf_we=0.
- Push: push = mem_valid & wb_allow_in. The entry is written at the tail on that clk edge and becomes visible at head/forwarding the next cycle; there is no same-cycle bypass.
- Pop: pop = head_valid & (rf_ready | ~head_writes), where head_writes = head_gr_we & (head_dest!=0).
- Writes to r0 or with gr_we=0 retire in 1 cycle without asserting rf_we.
- wb_allow_in = (count<DEPTH) | pop. When full, a simultaneous push and pop is legal and count holds.
- Count arithmetic: count in [0,DEPTH], width clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- rf_we = head_valid & head_writes, independent of rf_ready. rf_waddr and rf_wdata come from the head entry.
- The write is committed on cycles where rf_we & rf_ready. rf_we, rf_waddr and rf_wdata stay stable until that cycle.
- Debug outputs: debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata are the head fields.
- debug_wb_rf_we = {4{rf_we & rf_ready}}.
- Forwarding is combinational over valid entries with gr_we=1 and dest==fqN_addr, with fqN_addr!=0.
- The youngest match wins; this includes the head during the cycle it pops. No match gives hit=0 and data=0.
- Empty queue with mem_valid=0: all request outputs are 0.
- reset asserted mid-operation drops all entries the same edge; no rf write occurs in the reset cycle.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: adds output retire_cnt [63:0]. It is cleared by reset and increments by 1 on every pop, including r0 and no-write retires.
- Undefined: the port and counter are absent.

Test Plan:
- Basic retire:
  - Stimulus: reset, then push pc=0x1c000000, dest=5, result=0x1234, gr_we=1 with rf_ready=1.
  - Response: next cycle rf_we=1, waddr=5, wdata=0x1234, debug_wb_rf_we=4'hf. Cycle after, wb_empty=1.
- Backpressure, DEPTH=2:
  - Stimulus: rf_ready=0, push 3 entries back to back.
  - Response: two accepted, then wb_allow_in=0 and rf_we held with waddr of the first entry.
  - Stimulus: raise rf_ready.
  - Response: entries retire in order one per cycle; the third is accepted the cycle the first pops.
- r0 and no-write entries:
  - Stimulus: push dest=0, gr_we=1, and dest=7, gr_we=0, with rf_ready=0.
  - Response: both retire in consecutive cycles, rf_we=0 throughout.
- Forwarding priority:
  - Stimulus: rf_ready=0, queue holds dest=3/0xAAAA (older) and dest=3/0xBBBB (younger); set fq0_addr=3, fq1_addr=0.
  - Response: fq0_hit=1, fq0_data=0xBBBB; fq1_hit=0.
- Reset mid-operation:
  - Stimulus: full queue with rf_ready=0, assert reset one cycle.
  - Response: wb_empty=1, rf_we=0, fq0_hit=0 next cycle, and no debug write.
- Counter (WB_RETIRE_CNT_EN defined):
  - Stimulus: retire 5 entries, including one dest=0.
  - Response: retire_cnt=5.
